// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator side of the ALU operand interface. Collects a byte-serial frame
// (opcode, A, B) over a valid/ready handshake, drives registered operands and
// opcode into a combinational ALU, waits a settle period, captures the ALU
// result and offers it on a valid/ready result port.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous reset, active-high
//   in_data    - command byte
//   in_valid   - in_data valid
//   in_ready   - a byte is accepted this cycle (GET_OP/GET_A/GET_B only)
//   alu_a      - operand A to the ALU, registered, masked to OPERAND_W bits
//   alu_b      - operand B to the ALU, registered, masked to OPERAND_W bits
//   alu_op     - opcode to the ALU, registered
//   alu_result - combinational ALU output
//   res_data   - captured result
//   res_valid  - res_data valid
//   res_ready  - downstream accepts the result
//   busy       - high in any state other than GET_OP
//   frame_err  - one-cycle pulse when a partial frame is dropped by timeout
//   cmd_count  - completed commands, wraps 255 -> 0
module alu_cmd_sequencer #(
    parameter int unsigned OPERAND_W     = 6,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       frame_err,
    output logic [7:0] cmd_count
);

    localparam logic [7:0] OperandMask = 8'((9'd1 << OPERAND_W) - 9'd1);
    localparam logic [3:0] SettleLast  = 4'(SETTLE_CYCLES - 1);

    // Idle counter only has to reach TIMEOUT-1; the timeout fires on the edge
    // that would have taken it to TIMEOUT.
    localparam bit          TimeoutEn   = (TIMEOUT != 0);
    localparam int unsigned IdleW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TimeoutLim  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutLim);

    typedef enum logic [2:0] {
        StGetOp,
        StGetA,
        StGetB,
        StExec,
        StOut
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       cmd_count_q, cmd_count_d;
    logic [3:0]       settle_q, settle_d;
    logic [IdleW-1:0] idle_q, idle_d;

    logic xfer;
    logic timeout_hit;

    // in_ready decodes only the registered state, never in_valid.
    assign in_ready = (state_q == StGetOp) || (state_q == StGetA) || (state_q == StGetB);
    assign busy     = (state_q != StGetOp);

    assign xfer        = in_valid && in_ready;
    // A byte arriving on the timeout edge wins over the timeout.
    assign timeout_hit = TimeoutEn && !xfer && (idle_q == IdleLast);

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        frame_err_d = 1'b0;
        cmd_count_d = cmd_count_q;
        settle_d    = settle_q;
        idle_d      = idle_q;

        unique case (state_q)
            StGetOp: begin
                if (xfer) begin
                    alu_op_d = in_data[3:0];
                    idle_d   = '0;
                    state_d  = StGetA;
                end
            end
            StGetA: begin
                if (xfer) begin
                    alu_a_d = in_data & OperandMask;
                    idle_d  = '0;
                    state_d = StGetB;
                end else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    idle_d      = '0;
                    state_d     = StGetOp;
                end else if (TimeoutEn) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StGetB: begin
                if (xfer) begin
                    alu_b_d  = in_data & OperandMask;
                    idle_d   = '0;
                    settle_d = '0;
                    state_d  = StExec;
                end else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    idle_d      = '0;
                    state_d     = StGetOp;
                end else if (TimeoutEn) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StExec: begin
                if (settle_q == SettleLast) begin
                    res_data_d  = alu_result;
                    res_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StOut: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_count_d = cmd_count_q + 8'd1;
                    state_d     = StGetOp;
                end
            end
            default: state_d = StGetOp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StGetOp;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_count_q <= '0;
            settle_q    <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            frame_err_q <= frame_err_d;
            cmd_count_q <= cmd_count_d;
            settle_q    <= settle_d;
            idle_q      <= idle_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the ALU operand interface.
- Accepts a byte-serial command stream (op, A, B) over a valid/ready handshake.
- Drives registered operands and opcode into the combinational ALU, waits a settle period, captures the ALU result and returns it over a valid/ready result port.
- Sits between the pin-level byte interface and the ALU instance, replacing direct pin-to-operand wiring so that full 8-bit operands can be loaded over one bus.

Parameters:
- OPERAND_W, 6, significant operand bits. alu_a/alu_b bits [7:OPERAND_W] are forced to 0. Legal range 1..8.
- SETTLE_CYCLES, 1, cycles operands are held stable before the result is captured. Legal range 1..15.
- TIMEOUT, 255, idle cycles allowed between bytes of one frame before the frame is dropped. 0 disables the timeout.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous reset, active-high
- in_data  input  8  command byte
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer accepts a byte this cycle
- alu_a  output  8  operand A to ALU, registered
- alu_b  output  8  operand B to ALU, registered
- alu_op  output  4  opcode to ALU, registered
- alu_result  input  8  combinational ALU output
- res_data  output  8  captured result
- res_valid  output  1  res_data valid
- res_ready  input  1  downstream accepts the result
- busy  output  1  high in any state other than GET_OP
- frame_err  output  1  one-cycle pulse when a partial frame is dropped by timeout
- cmd_count  output  8  completed commands; increments on each result handshake; wraps 255->0

Behaviour:
- Reset, taken at the clock edge with reset=1 and applicable from any state, including mid-frame:
  - state=GET_OP.
  - alu_a=0, alu_b=0, alu_op=0.
  - res_data=0, res_valid=0, cmd_count=0, frame_err=0.
  - Settle and timeout counters cleared.
  - in_ready=1 from the first cycle after reset.
- Byte transfer occurs on any edge where in_valid and in_ready are both 1.
- in_ready=1 only in GET_OP, GET_A and GET_B. in_ready is a registered function of state only and does not depend on in_valid.
- Frame format: byte0 = opcode in [3:0] (bits [7:4] ignored); byte1 = A; byte2 = B.
- Operand masking: alu_a = {zeros, in_data[OPERAND_W-1:0]}; alu_b is masked the same way.
- States:
  - GET_OP: on transfer, alu_op<=in_data[3:0]; go to GET_A.
  - GET_A: on transfer, alu_a<=masked byte; go to GET_B.
  - GET_B: on transfer, alu_b<=masked byte; settle counter<=0; go to EXEC.
  - EXEC: settle counter increments each cycle. When it reaches SETTLE_CYCLES-1: res_data<=alu_result, res_valid<=1, go to OUT. EXEC therefore lasts exactly SETTLE_CYCLES cycles.
  - OUT: res_valid held high and res_data held stable until res_ready=1. On that edge: res_valid<=0, cmd_count<=cmd_count+1, go to GET_OP.
- Latency: the last B byte is accepted at edge N; res_valid is first high after edge N+SETTLE_CYCLES. Next byte0 acceptable in the cycle after the result handshake; no bypass.
- alu_a, alu_b and alu_op keep their last values after a command until overwritten. The ALU output therefore remains valid and observable between commands.
- Timeout (TIMEOUT>0):
  - Idle counter clears on every transfer and on entry to GET_A.
  - Idle counter increments each cycle in GET_A or GET_B without a transfer.
  - When the count reaches TIMEOUT: pulse frame_err for 1 cycle, go to GET_OP. Operand registers keep their partial values.
  - A transfer in the same cycle as the timeout wins: the byte is accepted and there is no error.
  - No timeout in GET_OP, EXEC or OUT.
- res_ready asserted while not in OUT is ignored.
- in_valid while in EXEC or OUT is ignored; the byte is not consumed.

Test Plan:
- Bench ALU model alu_result=alu_a+alu_b. Send 0x03, 0x05, 0x0A with in_valid held and res_ready=1 -> alu_op=3, alu_a=0x05, alu_b=0x0A; res_data=0x0F; res_valid high 1 cycle after the B transfer; cmd_count=1.
- Masking, OPERAND_W=6: send op 0x01, A=0xFF, B=0xC1 -> alu_a=0x3F, alu_b=0x01, res_data=0x40.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_valid and res_data stable, in_ready=0, busy=1; handshake on cycle 11 -> cmd_count increments once.
- Timeout, TIMEOUT=4: send op and A, then idle -> frame_err pulses exactly 4 cycles after the A transfer; next bytes 0x02, 0x01, 0x01 complete normally with res_data=0x02.
- Reset mid-frame: assert reset in GET_B -> next cycle all outputs are 0, in_ready=1; a fresh frame completes correctly.
- Wrap and settle, SETTLE_CYCLES=3: run 256 commands -> cmd_count=0; each result appears 3 cycles after its B transfer.
